// File: rtl/echo_align_pkg.sv
// rtl/echo_align_pkg.sv - shared types and constants for the echo reference delay aligner
//   DATA_WIDTH_DEF : default sample width
//   DROP_CNT_W     : width of the saturating drop counters
//   align_state_e  : PRIME (delay line filling) / RUN (delay line primed)
package echo_align_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int DROP_CNT_W     = 16;

    typedef enum logic [0:0] {
        ST_PRIME = 1'b0,
        ST_RUN   = 1'b1
    } align_state_e;

endpackage

// File: rtl/echo_align_dpram.sv
// rtl/echo_align_dpram.sv - simple dual-port RAM, one write port, one synchronous read port
//   clk              : clock
//   wr_en/addr/data  : write port
//   rd_en/addr       : read request, data appears on rd_data the next cycle
//   rd_data          : registered read data (old contents on same-address write)
module echo_align_dpram
    import echo_align_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = 1024,
    localparam int ADDR_W    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/echo_ref_delay_align.sv
// rtl/echo_ref_delay_align.sv - pairs far-end (x) and mic (d) samples, delaying x by a programmable bulk delay
//   clk, rst                 : clock, synchronous active-high reset
//   delay_cfg, cfg_load      : bulk delay value and its capture strobe
//   x_valid/x_data           : far-end reference sample stream
//   d_valid/d_data           : microphone sample stream
//   lms_full                 : downstream LMS input FIFO almost-full
//   lms_en_out/x_out/d_out   : one-cycle write of an aligned pair into the LMS
//   aligned                  : delay line primed
//   x_drop_cnt, d_drop_cnt   : saturating counts of discarded samples
module echo_ref_delay_align
    import echo_align_pkg::*;
#(
    parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int MAX_DELAY     = 1024,
    parameter int DEFAULT_DELAY = 0,
    localparam int ADDR_W       = $clog2(MAX_DELAY)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     delay_cfg,
    input  logic                  cfg_load,
    input  logic                  x_valid,
    input  logic [DATA_WIDTH-1:0] x_data,
    input  logic                  d_valid,
    input  logic [DATA_WIDTH-1:0] d_data,
    input  logic                  lms_full,
    output logic                  lms_en_out,
    output logic [DATA_WIDTH-1:0] lms_x_out,
    output logic [DATA_WIDTH-1:0] lms_d_out,
    output logic                  aligned,
    output logic [DROP_CNT_W-1:0] x_drop_cnt,
    output logic [DROP_CNT_W-1:0] d_drop_cnt
);

    localparam logic [ADDR_W-1:0] DEFAULT_DELAY_A = ADDR_W'(DEFAULT_DELAY);

    logic [DATA_WIDTH-1:0] x_hold;
    logic [DATA_WIDTH-1:0] d_hold;
    logic                  x_hold_v;
    logic                  d_hold_v;
    logic                  accept;
    logic                  x_load;
    logic                  d_load;

    logic [ADDR_W-1:0]     wr_ptr;
    logic [ADDR_W-1:0]     rd_addr;
    logic [ADDR_W-1:0]     delay_r;
    logic [ADDR_W-1:0]     fill_cnt;
    align_state_e          state;

    logic [DATA_WIDTH-1:0] ram_rd_data;
    logic [DATA_WIDTH-1:0] x_direct_q;
    logic                  use_ram_q;

    // A hold register can take a new sample if it is empty or is being drained this cycle.
    always_comb begin
        accept  = x_hold_v && d_hold_v && !lms_full;
        x_load  = x_valid && (!x_hold_v || accept);
        d_load  = d_valid && (!d_hold_v || accept);
        rd_addr = wr_ptr - delay_r;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_hold   <= '0;
            d_hold   <= '0;
            x_hold_v <= 1'b0;
            d_hold_v <= 1'b0;
        end else begin
            if (x_load) begin
                x_hold   <= x_data;
                x_hold_v <= 1'b1;
            end else if (accept) begin
                x_hold_v <= 1'b0;
            end
            if (d_load) begin
                d_hold   <= d_data;
                d_hold_v <= 1'b1;
            end else if (accept) begin
                d_hold_v <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_drop_cnt <= '0;
            d_drop_cnt <= '0;
        end else begin
            if (x_valid && !x_load && (x_drop_cnt != '1)) begin
                x_drop_cnt <= x_drop_cnt + 1'b1;
            end
            if (d_valid && !d_load && (d_drop_cnt != '1)) begin
                d_drop_cnt <= d_drop_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
        end else if (accept) begin
            wr_ptr <= wr_ptr + 1'b1;
        end
    end

    // A load restarts priming; an accept in the same cycle is not counted
    // toward the new delay, so stale RAM contents stay masked.
    always_ff @(posedge clk) begin
        if (rst) begin
            delay_r  <= DEFAULT_DELAY_A;
            fill_cnt <= '0;
            state    <= ST_PRIME;
        end else begin
            if (cfg_load) begin
                delay_r  <= delay_cfg;
                fill_cnt <= '0;
            end else if (accept && (fill_cnt < delay_r)) begin
                fill_cnt <= fill_cnt + 1'b1;
            end
            if (cfg_load) begin
                state <= ST_PRIME;
            end else if ((state == ST_PRIME) && (fill_cnt == delay_r)) begin
                state <= ST_RUN;
            end
        end
    end

    echo_align_dpram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MAX_DELAY)
    ) u_dpram (
        .clk     (clk),
        .wr_en   (accept),
        .wr_addr (wr_ptr),
        .wr_data (x_hold),
        .rd_en   (accept),
        .rd_addr (rd_addr),
        .rd_data (ram_rd_data)
    );

    // The bypass/silence path is registered alongside the RAM read so both
    // arrive in the cycle after accept; all registers only move on accept,
    // so the data outputs hold between writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            lms_en_out <= 1'b0;
            lms_d_out  <= '0;
            x_direct_q <= '0;
            use_ram_q  <= 1'b0;
        end else begin
            lms_en_out <= accept;
            if (accept) begin
                lms_d_out  <= d_hold;
                use_ram_q  <= (delay_r != '0) && (fill_cnt >= delay_r);
                x_direct_q <= (delay_r == '0) ? x_hold : '0;
            end
        end
    end

    always_comb begin
        lms_x_out = use_ram_q ? ram_rd_data : x_direct_q;
        aligned   = (state == ST_RUN);
    end

endmodule
